// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round constants, key-schedule state encoding
// and the word-rotation helper used by the key expansion.
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_READY  = 2'd2
    } ks_state_e;

    // Round constants for rounds 1..10; any other index yields zero.
    function automatic logic [7:0] get_rcon(input logic [3:0] round);
        logic [7:0] value;
        value = 8'h00;
        case (round)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197), shared by the key schedule and
// the encrypt engine.
module aes_sbox (
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);

    // Byte 0x00 sits in the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bitIdx;

    always_comb begin
        bitIdx = 11'd2047 - {sub_i, 3'b000};
        sub_o  = SBOX_TABLE[bitIdx -: 8];
    end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 round-key generator: expands one round key per cycle into an
// 11-entry store and serves entries through a registered indexed read port.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             halt,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid,
    output logic             busy,
    output logic             key_ready
);

    ks_state_e        state_q, state_d;
    logic [3:0]       ctr_q;
    logic [KEY_W-1:0] store_q [0:NUM_ROUNDS];
    logic [KEY_W-1:0] rkOut_q;
    logic             rkValid_q;

    logic [KEY_W-1:0] prevKey;
    logic [KEY_W-1:0] nextKey;
    logic [31:0]      rotWord;
    logic [31:0]      subWord;
    logic [31:0]      tWord;
    logic [31:0]      w0, w1, w2, w3;

    // Next round key is always derived from the entry just below the counter.
    always_comb begin
        prevKey = store_q[ctr_q - 4'd1];
        rotWord = rot_word(prevKey[31:0]);
    end

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .sub_i (rotWord[8*b +: 8]),
            .sub_o (subWord[8*b +: 8])
        );
    end

    always_comb begin
        tWord   = subWord ^ {get_rcon(ctr_q), 24'h000000};
        w0      = prevKey[127:96] ^ tWord;
        w1      = prevKey[95:64]  ^ w0;
        w2      = prevKey[63:32]  ^ w1;
        w3      = prevKey[31:0]   ^ w2;
        nextKey = {w0, w1, w2, w3};
    end

    // Halt beats key_load; key_load restarts from any state.
    always_comb begin
        state_d = state_q;
        if (halt) begin
            state_d = KS_IDLE;
        end else if (key_load) begin
            state_d = KS_EXPAND;
        end else begin
            case (state_q)
                KS_EXPAND: if (ctr_q == 4'(NUM_ROUNDS)) state_d = KS_READY;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Key store and round counter; halt zeroizes exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || halt) begin
            ctr_q <= 4'd0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                store_q[i] <= '0;
            end
        end else if (key_load) begin
            store_q[0] <= key_in;
            ctr_q      <= 4'd1;
        end else if (state_q == KS_EXPAND) begin
            store_q[ctr_q] <= nextKey;
            ctr_q          <= (ctr_q == 4'(NUM_ROUNDS)) ? 4'd0 : ctr_q + 4'd1;
        end
    end

    // Read port uses the pre-edge ready state so a partial key is never served.
    always_ff @(posedge clk) begin
        if (rst || halt) begin
            rkOut_q   <= '0;
            rkValid_q <= 1'b0;
        end else if (state_q == KS_READY && rk_idx <= 4'(NUM_ROUNDS)) begin
            rkOut_q   <= store_q[rk_idx];
            rkValid_q <= 1'b1;
        end else begin
            rkOut_q   <= '0;
            rkValid_q <= 1'b0;
        end
    end

    assign rk_out    = rkOut_q;
    assign rk_valid  = rkValid_q;
    assign busy      = (state_q == KS_EXPAND);
    assign key_ready = (state_q == KS_READY);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         halt;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         busy;
    logic         key_ready;

    int compared;
    int mismatched;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .halt      (halt),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .key_ready (key_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse key_load for one cycle; returns at the negedge after the load edge.
    task automatic load_key(input logic [127:0] k);
        @(negedge clk);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        key_in   = '0;
    endtask

    // Wait (bounded) for key_ready, counting cycles, busy cycles and any rk_valid.
    task automatic wait_ready(output int cycles, output int busyCnt, output int validCnt);
        cycles   = 0;
        busyCnt  = 0;
        validCnt = 0;
        while (!key_ready && cycles < 30) begin
            if (busy) busyCnt++;
            if (rk_valid) validCnt++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] data, output logic valid);
        rk_idx = idx;
        @(negedge clk);
        data  = rk_out;
        valid = rk_valid;
    endtask

    task automatic test_reset();
        logic [127:0] d;
        logic v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0 || key_ready !== 1'b0 || rk_valid !== 1'b0 || rk_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: busy=%b ready=%b valid=%b out=%h, expected all zero",
                     busy, key_ready, rk_valid, rk_out);
        end
        read_rk(4'd0, d, v);
        compared++;
        if (v !== 1'b0 || d !== '0) begin
            mismatched++;
            $display("[TB] FAIL read_before_ready: valid=%b out=%h, expected 0/0", v, d);
        end
    endtask

    task automatic test_fips_a1();
        int cyc, bc, vc;
        logic [127:0] d;
        logic v;
        rk_idx = 4'd0;
        load_key(KEY_A);
        wait_ready(cyc, bc, vc);
        compared++;
        if (cyc !== 10) begin
            mismatched++;
            $display("[TB] FAIL a1_latency: got %0d cycles, expected 10", cyc);
        end
        compared++;
        if (vc !== 0) begin
            mismatched++;
            $display("[TB] FAIL a1_valid_during_expand: got %0d valid cycles, expected 0", vc);
        end
        read_rk(4'd1, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_A_R1) begin
            mismatched++;
            $display("[TB] FAIL a1_rk1: valid=%b out=%h, expected 1/%h", v, d, KEY_A_R1);
        end
        read_rk(4'd2, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_A_R2) begin
            mismatched++;
            $display("[TB] FAIL a1_rk2: valid=%b out=%h, expected 1/%h", v, d, KEY_A_R2);
        end
        read_rk(4'd10, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_A_RA) begin
            mismatched++;
            $display("[TB] FAIL a1_rk10: valid=%b out=%h, expected 1/%h", v, d, KEY_A_RA);
        end
    endtask

    task automatic test_key_b();
        int cyc, bc, vc;
        logic [127:0] d;
        logic v;
        load_key(KEY_B);
        wait_ready(cyc, bc, vc);
        compared++;
        if (bc !== 10 || cyc !== 10) begin
            mismatched++;
            $display("[TB] FAIL b_busy_len: busy=%0d latency=%0d, expected 10/10", bc, cyc);
        end
        read_rk(4'd0, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_B) begin
            mismatched++;
            $display("[TB] FAIL b_rk0: valid=%b out=%h, expected 1/%h", v, d, KEY_B);
        end
        read_rk(4'd1, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_B_R1) begin
            mismatched++;
            $display("[TB] FAIL b_rk1: valid=%b out=%h, expected 1/%h", v, d, KEY_B_R1);
        end
        read_rk(4'd10, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_B_RA) begin
            mismatched++;
            $display("[TB] FAIL b_rk10: valid=%b out=%h, expected 1/%h", v, d, KEY_B_RA);
        end
    endtask

    task automatic test_read_guard();
        logic [127:0] d;
        logic v;
        for (int i = 11; i <= 15; i++) begin
            read_rk(4'(i), d, v);
            compared++;
            if (v !== 1'b0 || d !== '0) begin
                mismatched++;
                $display("[TB] FAIL idx_out_of_range[%0d]: valid=%b out=%h, expected 0/0", i, v, d);
            end
        end
    endtask

    task automatic test_restart();
        int cyc, bc, vc;
        logic [127:0] d;
        logic v;
        rk_idx = 4'd10;
        load_key(KEY_A);
        repeat (4) @(negedge clk);
        load_key(KEY_B);
        wait_ready(cyc, bc, vc);
        compared++;
        if (cyc !== 10 || vc !== 0) begin
            mismatched++;
            $display("[TB] FAIL restart_latency: latency=%0d valid=%0d, expected 10/0", cyc, vc);
        end
        read_rk(4'd10, d, v);
        compared++;
        if (v !== 1'b1 || d !== KEY_B_RA) begin
            mismatched++;
            $display("[TB] FAIL restart_rk10: valid=%b out=%h, expected 1/%h", v, d, KEY_B_RA);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc, vc;
        rk_idx = 4'd10;
        @(negedge clk);
        key_in   = KEY_A;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        compared++;
        if (rk_valid !== 1'b1 || rk_out !== KEY_B_RA || key_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_read_old: valid=%b out=%h ready=%b, expected 1/%h/0",
                     rk_valid, rk_out, key_ready, KEY_B_RA);
        end
        @(negedge clk);
        compared++;
        if (rk_valid !== 1'b0 || rk_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL load_read_after: valid=%b out=%h, expected 0/0", rk_valid, rk_out);
        end
        wait_ready(cyc, bc, vc);
        compared++;
        if (cyc !== 9) begin
            mismatched++;
            $display("[TB] FAIL b2b_latency: got %0d more cycles, expected 9", cyc);
        end
    endtask

    task automatic test_halt();
        int cyc, bc, vc;
        logic [127:0] d;
        logic v;
        rk_idx = 4'd1;
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        compared++;
        if (key_ready !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0 || rk_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL halt_ready: ready=%b busy=%b valid=%b out=%h, expected all zero",
                     key_ready, busy, rk_valid, rk_out);
        end
        load_key(KEY_B);
        wait_ready(cyc, bc, vc);
        @(negedge clk);
        halt     = 1'b1;
        key_load = 1'b1;
        key_in   = KEY_A;
        @(negedge clk);
        halt     = 1'b0;
        key_load = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (key_ready !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL halt_beats_load: ready=%b busy=%b valid=%b, expected 0/0/0",
                     key_ready, busy, rk_valid);
        end
        load_key(KEY_A);
        wait_ready(cyc, bc, vc);
        read_rk(4'd1, d, v);
        compared++;
        if (cyc !== 10 || v !== 1'b1 || d !== KEY_A_R1) begin
            mismatched++;
            $display("[TB] FAIL halt_reload: latency=%0d valid=%b out=%h, expected 10/1/%h",
                     cyc, v, d, KEY_A_R1);
        end
    endtask

    task automatic test_rst_mid();
        int cyc, bc, vc;
        logic [127:0] d;
        logic v;
        load_key(KEY_B);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0 || key_ready !== 1'b0 || rk_valid !== 1'b0 || rk_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid: busy=%b ready=%b valid=%b out=%h, expected all zero",
                     busy, key_ready, rk_valid, rk_out);
        end
        load_key(KEY_A);
        wait_ready(cyc, bc, vc);
        read_rk(4'd10, d, v);
        compared++;
        if (cyc !== 10 || v !== 1'b1 || d !== KEY_A_RA) begin
            mismatched++;
            $display("[TB] FAIL rst_reload: latency=%0d valid=%b out=%h, expected 10/1/%h",
                     cyc, v, d, KEY_A_RA);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        key_load   = 1'b0;
        key_in     = '0;
        halt       = 1'b0;
        rk_idx     = 4'd0;
        test_reset();
        test_fips_a1();
        test_key_b();
        test_read_guard();
        test_restart();
        test_back_to_back();
        test_halt();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
